// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

    // Funct3 operation codes
    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    // Funct7 that routes an OP (7'b0110011) instruction to this unit
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Funct3[2] separates divide/remainder from multiply
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    // RS1 is signed for everything except the fully unsigned forms
    function automatic logic rs1_signed(input logic [2:0] f3);
        return !(f3 == MULHU || f3 == DIVU || f3 == REMU);
    endfunction

    // RS2 is signed only for the fully signed forms
    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == MUL || f3 == MULH || f3 == DIV || f3 == REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc = {partial high, multiplier being shifted out}, opnd = multiplicand.
// Divide:   acc[W-1:0] = dividend shifting out MSB-first with quotient bits
//           entering at the LSB, opnd = divisor, rem = partial remainder.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    input  logic [WIDTH:0]       rem,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic [WIDTH:0]       rem_next
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Add multiplicand into the high half when the current multiplier bit is set
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Bring the next dividend bit into the partial remainder and try a subtract
    assign shifted = {rem[WIDTH-1:0], acc[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, opnd};

    // Select the next accumulator/remainder for the active operation
    always_comb begin
        acc_next = acc;
        rem_next = rem;
        if (is_div) begin
            if (trial[WIDTH+1]) begin
                rem_next = shifted;
                acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            end else begin
                rem_next = trial[WIDTH:0];
                acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// Operands are converted to magnitudes at accept; the sign is reapplied in FIX.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] RS1,
    input  logic [WIDTH-1:0] RS2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RD
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     rem;
    logic               neg_q;      // sign of product / quotient
    logic               neg_r;      // sign of remainder
    logic               special;
    logic [WIDTH-1:0]   spec_val;

    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     rem_next;

    // Accept-time decode
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero, div_ovf;
    logic [WIDTH-1:0]   spec_in;

    // FIX-time result
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, result;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_op(op)),
        .acc      (acc),
        .opnd     (opnd),
        .rem      (rem),
        .acc_next (acc_next),
        .rem_next (rem_next)
    );

    // Operand magnitudes and special-case detection for the incoming op
    always_comb begin
        sa       = rs1_signed(Funct3) & RS1[WIDTH-1];
        sb       = rs2_signed(Funct3) & RS2[WIDTH-1];
        mag_a    = sa ? (~RS1 + 1'b1) : RS1;
        mag_b    = sb ? (~RS2 + 1'b1) : RS2;
        div_zero = is_div_op(Funct3) && (RS2 == '0);
        div_ovf  = (Funct3 == DIV || Funct3 == REM) && (RS1 == MIN_NEG) && (RS2 == '1);
        spec_in  = '0;
        if (div_zero)
            spec_in = Funct3[1] ? RS1 : '1;
        else if (div_ovf)
            spec_in = Funct3[1] ? '0 : RS1;
    end

    // Sign correction and result selection
    always_comb begin
        prod_fix = neg_q ? (~acc + 1'b1) : acc;
        quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        case (op)
            MUL:             result = prod_fix[WIDTH-1:0];
            MULH, MULHSU,
            MULHU:           result = prod_fix[2*WIDTH-1:WIDTH];
            DIV, DIVU:       result = quo_fix;
            default:         result = rem_fix;
        endcase
        if (special)
            result = spec_val;
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            RD        <= '0;
            cnt       <= '0;
            op        <= MUL;
            acc       <= '0;
            opnd      <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            special   <= 1'b0;
            spec_val  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= Funct3;
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        rem      <= '0;
                        cnt      <= CNT_W'(WIDTH-1);
                        special  <= div_zero | div_ovf;
                        spec_val <= spec_in;
                        in_ready <= 1'b0;
                        if (is_div_op(Funct3)) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                        state <= (div_zero | div_ovf) ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    RD        <= result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  Funct3;
    logic [31:0] RS1, RS2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] RD;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Funct3    (Funct3),
        .RS1       (RS1),
        .RS2       (RS2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .RD        (RD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges to out_valid, check result, then handshake it out.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        int edges;
        logic rdy_low;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        Funct3   = f;
        RS1      = a;
        RS2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: the op must have been captured at accept
        Funct3 = ~f;
        RS1    = 32'hDEAD_BEEF;
        RS2    = 32'h0000_0000;
        edges   = 0;
        rdy_low = 1'b1;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (in_ready) rdy_low = 1'b0;
        end while (!out_valid && edges < 200);
        chk({tag, "_latency"}, edges, lat);
        chk({tag, "_busy_not_ready"}, {31'd0, rdy_low}, 32'd1);
        chk({tag, "_rd"}, RD, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_post_hs_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_post_hs_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_rd_retained"}, RD, exp);
    endtask

    initial begin
        int edges;
        logic stable;
        logic leaked;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Funct3    = 3'd0;
        RS1       = '0;
        RS2       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_rd", RD, 32'd0);
        rst = 1'b0;

        // Multiply family
        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);

        // Divide family
        run_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
        run_op("remu", 3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33);
        run_op("div_neg_divisor", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
        run_op("rem_neg_divisor", 3'd6, 32'd100, 32'hFFFF_FFF9, 32'd2, 33);

        // Special cases with the short path
        run_op("div_by_zero",  3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_by_zero", 3'd7, 32'd5,          32'd0,         32'h0000_0005, 1);
        run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Backpressure: hold the result, offer a competing op that must be ignored
        @(negedge clk);
        Funct3   = 3'd0;
        RS1      = 32'd6;
        RS2      = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("bp_latency", edges, 33);
        chk("bp_rd", RD, 32'd42);
        Funct3   = 3'd5;
        RS1      = 32'd100;
        RS2      = 32'd3;
        in_valid = 1'b1;
        stable   = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (RD !== 32'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        chk("bp_hold_stable", {31'd0, stable}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_hs_ready", {31'd0, in_ready}, 32'd1);
        leaked = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) leaked = 1'b1;
        end
        chk("bp_ignored_op", {31'd0, leaked}, 32'd0);
        chk("bp_rd_retained", RD, 32'd42);
        run_op("after_bp", 3'd5, 32'd100, 32'd3, 32'd33, 33);

        // Reset in the middle of a divide
        @(negedge clk);
        Funct3   = 3'd4;
        RS1      = 32'd1000;
        RS2      = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_rd", RD, 32'd0);
        leaked = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) leaked = 1'b1;
        end
        chk("midreset_no_result", {31'd0, leaked}, 32'd0);
        run_op("mul_after_reset", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
